// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: word width and FSM state encoding.
package memory_responder_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StRespond,
    StRecover
  } responder_state_e;

endpackage

// File: rtl/memory_responder_storage.sv
// Word storage for the memory responder: synchronous write, combinational read.
// Contents are deliberately not reset; they are undefined until written.
module memory_responder_storage
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IdxW-1:0]       addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  // Write port: commits on the rising edge when enabled
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read port: asynchronous lookup of the addressed word
  always_comb begin
    rdata_o = mem_q[addr_i];
  end

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding-request memory responder. A request accepted in IDLE is latched,
// waits LATENCY cycles in BUSY, completes with a one-cycle readyOut pulse in RESPOND,
// then spends one RECOVER cycle ignoring inputs so a still-held request is not re-taken.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic [WORD_WIDTH-1:0] addressIn,
  input  logic [WORD_WIDTH-1:0] valueIn,
  input  logic                  loadIn,
  input  logic                  storeIn,
  output logic [WORD_WIDTH-1:0] valueOut,
  output logic                  readyOut
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  responder_state_e      state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  is_store_q, is_store_d;

  logic                  req;
  logic                  mem_we;
  logic [WORD_WIDTH-1:0] mem_rdata;

  // Byte-offset bits and bits above the word index take no part in addressing
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addressIn[WORD_WIDTH-1:2+IdxW], addressIn[1:0]};

  assign req = loadIn | storeIn;

  // State register
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req) state_d = StBusy;
      StBusy:    if (cnt_q == '0) state_d = StRespond;
      StRespond: state_d = StRecover;
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Request latch and latency counter next-state; inputs only sampled in IDLE
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    is_store_d = is_store_q;
    if (state_q == StIdle && req) begin
      idx_d      = addressIn[2 +: IdxW];
      data_d     = valueIn;
      // Simultaneous load and store is treated as a store
      is_store_d = storeIn;
      cnt_d      = CntLoad;
    end else if (state_q == StBusy && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Request latch and latency counter registers
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      is_store_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      is_store_q <= is_store_d;
    end
  end

  // Outputs: completion pulse, response data and write strobe, all from RESPOND
  always_comb begin
    readyOut = 1'b0;
    valueOut = '0;
    mem_we   = 1'b0;
    if (state_q == StRespond) begin
      readyOut = 1'b1;
      valueOut = is_store_q ? data_q : mem_rdata;
      // A reset on the RESPOND edge aborts the store
      mem_we   = is_store_q & ~resetIn;
    end
  end

  memory_responder_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk_i  (clockIn),
    .we_i   (mem_we),
    .addr_i (idx_q),
    .wdata_i(data_q),
    .rdata_o(mem_rdata)
  );

endmodule
